// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - shared RV32I types and opcode constants for the instruction loader
package instr_encoder_pkg;

    typedef enum logic [1:0] {
        TYPE_I = 2'd0,
        TYPE_S = 2'd1,
        TYPE_R = 2'd2,
        TYPE_B = 2'd3
    } instrType_t;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;

endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - field-level instruction request stream with ready/valid handshake
interface instr_encoder_if;
    import instr_encoder_pkg::*;

    logic       i_valid;
    logic       o_ready;
    logic       i_last;
    instrType_t i_instrType;
    logic [4:0] i_rd;
    logic [4:0] i_rs1;
    logic [4:0] i_rs2;
    logic [2:0] i_funct3;
    logic       i_funct7bit5;
    logic [12:0] i_imm;

    modport master (
        output i_valid, i_last, i_instrType, i_rd, i_rs1, i_rs2,
               i_funct3, i_funct7bit5, i_imm,
        input  o_ready
    );

    modport slave (
        input  i_valid, i_last, i_instrType, i_rd, i_rs1, i_rs2,
               i_funct3, i_funct7bit5, i_imm,
        output o_ready
    );
endinterface

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational packing of instruction fields into a 32-bit RV32I word
module instr_pack
    import instr_encoder_pkg::*;
(
    input  instrType_t  i_instrType,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic        i_funct7bit5,
    input  logic [12:0] i_imm,
    output logic [31:0] o_word
);
    logic [6:0] w_funct7;
    logic       w_unused_imm0;

    assign w_funct7      = i_funct7bit5 ? FUNCT7_ALT : 7'b0000000;
    // Branch offsets are halfword aligned, so bit 0 never reaches the word.
    assign w_unused_imm0 = i_imm[0];

    always_comb begin
        o_word = '0;
        case (i_instrType)
            TYPE_R: o_word = {w_funct7, i_rs2, i_rs1, i_funct3, i_rd, OPCODE_RTYPE};
            TYPE_I: o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPCODE_LOAD};
            TYPE_S: o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OPCODE_STORE};
            TYPE_B: o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                              i_imm[4:1], i_imm[11], OPCODE_BRANCH};
            default: o_word = '0;
        endcase
    end
endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes an instruction request stream and writes it into instruction memory
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    instr_encoder_if.slave    i_req,
    input  logic              i_restart,
    output logic              o_memWriteEn,
    output logic [ADDR_W-1:0] o_memAddr,
    output logic [31:0]       o_memWriteData,
    output logic [ADDR_W:0]   o_count,
    output logic              o_done,
    output logic              o_full
);
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            r_state;
    state_t            w_next_state;
    logic              w_accept;
    logic              w_terminal;
    logic [31:0]       w_word;
    logic [ADDR_W-1:0] r_next_addr;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_data;
    logic [ADDR_W:0]   r_count;
    logic              r_full;

    instr_pack u_pack (
        .i_instrType  (i_req.i_instrType),
        .i_rd         (i_req.i_rd),
        .i_rs1        (i_req.i_rs1),
        .i_rs2        (i_req.i_rs2),
        .i_funct3     (i_req.i_funct3),
        .i_funct7bit5 (i_req.i_funct7bit5),
        .i_imm        (i_req.i_imm),
        .o_word       (w_word)
    );

    assign w_terminal = (r_next_addr == LAST_ADDR);

    always_comb begin
        w_next_state  = r_state;
        w_accept      = 1'b0;
        i_req.o_ready = 1'b0;
        o_done        = 1'b0;
        case (r_state)
            ST_LOAD: begin
                i_req.o_ready = 1'b1;
                w_accept      = i_req.i_valid;
                // The terminal address always ends the load so the counter never wraps.
                if (w_accept && (i_req.i_last || w_terminal)) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: w_next_state = ST_DONE;
            ST_DONE: begin
                o_done = 1'b1;
                if (i_restart) begin
                    w_next_state = ST_LOAD;
                end
            end
            default: w_next_state = ST_LOAD;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_next_addr <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
        end else begin
            r_mem_we <= w_accept;
            if (w_accept) begin
                r_mem_addr  <= r_next_addr;
                r_mem_data  <= w_word;
                r_next_addr <= r_next_addr + 1'b1;
                if (w_terminal) begin
                    r_full <= 1'b1;
                end
            end
            // Count lags the strobe by one edge: it tallies writes already on the port.
            if (r_mem_we) begin
                r_count <= r_count + 1'b1;
            end
            if (r_state == ST_DONE && i_restart) begin
                r_next_addr <= '0;
                r_count     <= '0;
                r_full      <= 1'b0;
            end
        end
    end

    assign o_memWriteEn   = r_mem_we;
    assign o_memAddr      = r_mem_addr;
    assign o_memWriteData = r_mem_data;
    assign o_count        = r_count;
    assign o_full         = r_full;
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder with a field-level reference encoder
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    typedef struct {
        instrType_t t;
        int rd, rs1, rs2, f3, f7b5, imm;
    } req_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic restart6, restart2;

    instr_encoder_if bus6();
    instr_encoder_if bus2();

    logic        we6, we2;
    logic [5:0]  addr6;
    logic [1:0]  addr2;
    logic [31:0] data6, data2;
    logic [6:0]  count6;
    logic [2:0]  count2;
    logic        done6, done2, full6, full2;

    instr_encoder #(.ADDR_W(6)) dut6 (
        .i_clk(clk), .i_rst(rst), .i_req(bus6.slave), .i_restart(restart6),
        .o_memWriteEn(we6), .o_memAddr(addr6), .o_memWriteData(data6),
        .o_count(count6), .o_done(done6), .o_full(full6)
    );

    instr_encoder #(.ADDR_W(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_req(bus2.slave), .i_restart(restart2),
        .o_memWriteEn(we2), .o_memAddr(addr2), .o_memWriteData(data2),
        .o_count(count2), .o_done(done2), .o_full(full2)
    );

    int errors = 0;
    int checks = 0;

    // Reference encoder: builds the word from field values with plain integer arithmetic.
    function automatic logic [31:0] ref_encode(req_t r);
        int unsigned u;
        int unsigned w;
        u = r.imm;
        w = (r.rs1 * 32768) + (r.f3 * 4096);
        case (r.t)
            TYPE_R: w = w + (r.f7b5 != 0 ? 32 * 33554432 : 0) + r.rs2 * 1048576 + r.rd * 128 + 51;
            TYPE_I: w = w + (u % 4096) * 1048576 + r.rd * 128 + 3;
            TYPE_S: w = w + ((u / 32) % 128) * 33554432 + r.rs2 * 1048576 + (u % 32) * 128 + 35;
            TYPE_B: w = w + ((u / 4096) % 2) * 32'h8000_0000 + ((u / 32) % 64) * 33554432
                          + r.rs2 * 1048576 + ((u / 2) % 16) * 256 + ((u / 2048) % 2) * 128 + 99;
            default: w = 0;
        endcase
        return w;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.t    = instrType_t'($urandom_range(0, 3));
        r.rd   = int'($urandom_range(0, 31));
        r.rs1  = int'($urandom_range(0, 31));
        r.rs2  = int'($urandom_range(0, 31));
        r.f3   = int'($urandom_range(0, 7));
        r.f7b5 = int'($urandom_range(0, 1));
        r.imm  = int'($urandom_range(0, 8191)) - 4096;
        return r;
    endfunction

    task automatic drive6(req_t r, bit v, bit l);
        bus6.i_valid = v;  bus6.i_last = l;  bus6.i_instrType = r.t;
        bus6.i_rd = 5'(r.rd);  bus6.i_rs1 = 5'(r.rs1);  bus6.i_rs2 = 5'(r.rs2);
        bus6.i_funct3 = 3'(r.f3);  bus6.i_funct7bit5 = r.f7b5[0];  bus6.i_imm = 13'(r.imm);
    endtask

    task automatic drive2(req_t r, bit v, bit l);
        bus2.i_valid = v;  bus2.i_last = l;  bus2.i_instrType = r.t;
        bus2.i_rd = 5'(r.rd);  bus2.i_rs1 = 5'(r.rs1);  bus2.i_rs2 = 5'(r.rs2);
        bus2.i_funct3 = 3'(r.f3);  bus2.i_funct7bit5 = r.f7b5[0];  bus2.i_imm = 13'(r.imm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req_t z;
        z = '{TYPE_I, 0, 0, 0, 0, 0, 0};
        rst = 1'b1;
        drive6(z, 1'b0, 1'b0);
        drive2(z, 1'b0, 1'b0);
        tick(); tick();
        checks++; if (bus6.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", bus6.o_ready); end
        checks++; if (we6 !== 1'b0) begin errors++; $display("FAIL reset_we got=%0b exp=0", we6); end
        checks++; if (addr6 !== 6'd0) begin errors++; $display("FAIL reset_addr got=%0h exp=0", addr6); end
        checks++; if (data6 !== 32'd0) begin errors++; $display("FAIL reset_data got=%0h exp=0", data6); end
        checks++; if (count6 !== 7'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count6); end
        checks++; if (done6 !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done6); end
        checks++; if (full6 !== 1'b0) begin errors++; $display("FAIL reset_full got=%0b exp=0", full6); end
        checks++; if ({bus2.o_ready, done2, full2} !== 3'b100) begin errors++; $display("FAIL reset_dut2 got=%03b exp=100", {bus2.o_ready, done2, full2}); end
        rst = 1'b0;
    endtask

    task automatic test_fixed_vectors();
        req_t        v[5];
        logic [31:0] e[5];
        v[0] = '{TYPE_I, 6, 9, 0, 2, 0, -4};  e[0] = 32'hFFC4A303;
        v[1] = '{TYPE_S, 0, 9, 6, 2, 0, 8};   e[1] = 32'h0064A423;
        v[2] = '{TYPE_R, 4, 5, 6, 6, 0, 0};   e[2] = 32'h0062E233;
        v[3] = '{TYPE_R, 4, 5, 6, 0, 1, 0};   e[3] = 32'h40628233;
        v[4] = '{TYPE_B, 0, 4, 4, 0, 0, -8};  e[4] = 32'hFE420CE3;
        for (int i = 0; i < 5; i++) begin
            drive6(v[i], 1'b1, 1'b1);
            tick();
            drive6(v[i], 1'b0, 1'b0);
            checks++; if (we6 !== 1'b1 || addr6 !== 6'd0) begin errors++; $display("FAIL vec%0d_strobe got=%0b/%0h exp=1/0", i, we6, addr6); end
            checks++; if (data6 !== e[i]) begin errors++; $display("FAIL vec%0d_data got=%08h exp=%08h", i, data6, e[i]); end
            tick();
            checks++; if (done6 !== 1'b1 || count6 !== 7'd1 || we6 !== 1'b0) begin errors++; $display("FAIL vec%0d_done got=%0b/%0d/%0b exp=1/1/0", i, done6, count6, we6); end
            restart6 = 1'b1;
            tick();
            restart6 = 1'b0;
            checks++; if (count6 !== 7'd0 || bus6.o_ready !== 1'b1 || done6 !== 1'b0) begin errors++; $display("FAIL vec%0d_restart got=%0d/%0b/%0b exp=0/1/0", i, count6, bus6.o_ready, done6); end
        end
    endtask

    task automatic test_back_to_back();
        req_t r;
        for (int i = 0; i < 3; i++) begin
            r = rand_req();
            drive6(r, 1'b1, i == 2);
            restart6 = (i == 1);
            tick();
            checks++; if (we6 !== 1'b1 || addr6 !== 6'(i)) begin errors++; $display("FAIL b2b%0d_strobe got=%0b/%0h exp=1/%0h", i, we6, addr6, i); end
            checks++; if (data6 !== ref_encode(r)) begin errors++; $display("FAIL b2b%0d_data got=%08h exp=%08h", i, data6, ref_encode(r)); end
        end
        restart6 = 1'b0;
        checks++; if (bus6.o_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low got=%0b exp=0", bus6.o_ready); end
        drive6(r, 1'b1, 1'b0);
        tick();
        checks++; if (done6 !== 1'b1 || count6 !== 7'd3 || we6 !== 1'b0) begin errors++; $display("FAIL b2b_done got=%0b/%0d/%0b exp=1/3/0", done6, count6, we6); end
        tick();
        checks++; if (we6 !== 1'b0 || count6 !== 7'd3 || done6 !== 1'b1) begin errors++; $display("FAIL done_ignores_valid got=%0b/%0d/%0b exp=0/3/1", we6, count6, done6); end
        drive6(r, 1'b0, 1'b0);
        restart6 = 1'b1;
        tick();
        restart6 = 1'b0;
        checks++; if (count6 !== 7'd0 || bus6.o_ready !== 1'b1) begin errors++; $display("FAIL b2b_restart got=%0d/%0b exp=0/1", count6, bus6.o_ready); end
        r = rand_req();
        drive6(r, 1'b1, 1'b1);
        tick();
        drive6(r, 1'b0, 1'b0);
        checks++; if (we6 !== 1'b1 || addr6 !== 6'd0 || data6 !== ref_encode(r)) begin errors++; $display("FAIL b2b_after_restart got=%0b/%0h/%08h exp=1/0/%08h", we6, addr6, data6, ref_encode(r)); end
        tick();
        restart6 = 1'b1;
        tick();
        restart6 = 1'b0;
    endtask

    task automatic test_random_streams();
        req_t r;
        int   len, k;
        bit   v;
        for (int s = 0; s < 6; s++) begin
            len = int'($urandom_range(1, 8));
            k = 0;
            for (int cyc = 0; cyc < 64 && k < len; cyc++) begin
                r = rand_req();
                v = ($urandom_range(0, 3) != 0);
                drive6(r, v, k == len - 1);
                tick();
                if (v) begin
                    checks++; if (we6 !== 1'b1 || addr6 !== 6'(k) || data6 !== ref_encode(r)) begin errors++; $display("FAIL rnd%0d_w%0d got=%0b/%0h/%08h exp=1/%0h/%08h", s, k, we6, addr6, data6, k, ref_encode(r)); end
                    checks++; if (count6 !== 7'(k)) begin errors++; $display("FAIL rnd%0d_cnt%0d got=%0d exp=%0d", s, k, count6, k); end
                    k++;
                end else begin
                    checks++; if (we6 !== 1'b0 || (k > 0 && addr6 !== 6'(k - 1))) begin errors++; $display("FAIL rnd%0d_gap got=%0b/%0h exp=0/%0h", s, we6, addr6, k - 1); end
                end
            end
            drive6(r, 1'b0, 1'b0);
            tick();
            checks++; if (done6 !== 1'b1 || count6 !== 7'(len)) begin errors++; $display("FAIL rnd%0d_done got=%0b/%0d exp=1/%0d", s, done6, count6, len); end
            restart6 = 1'b1;
            tick();
            restart6 = 1'b0;
        end
    endtask

    task automatic test_full();
        req_t r;
        for (int i = 0; i < 5; i++) begin
            r = rand_req();
            drive2(r, 1'b1, 1'b0);
            tick();
            if (i < 4) begin
                checks++; if (we2 !== 1'b1 || addr2 !== 2'(i) || data2 !== ref_encode(r)) begin errors++; $display("FAIL full_w%0d got=%0b/%0h/%08h exp=1/%0h/%08h", i, we2, addr2, data2, i, ref_encode(r)); end
                checks++; if (full2 !== (i == 3)) begin errors++; $display("FAIL full_flag%0d got=%0b exp=%0b", i, full2, i == 3); end
            end else begin
                checks++; if (we2 !== 1'b0 || done2 !== 1'b1) begin errors++; $display("FAIL full_fifth got=%0b/%0b exp=0/1", we2, done2); end
            end
        end
        drive2(r, 1'b0, 1'b0);
        tick();
        checks++; if (count2 !== 3'd4 || full2 !== 1'b1 || done2 !== 1'b1) begin errors++; $display("FAIL full_final got=%0d/%0b/%0b exp=4/1/1", count2, full2, done2); end
        restart2 = 1'b1;
        tick();
        restart2 = 1'b0;
        checks++; if (full2 !== 1'b0 || count2 !== 3'd0 || bus2.o_ready !== 1'b1) begin errors++; $display("FAIL full_restart got=%0b/%0d/%0b exp=0/0/1", full2, count2, bus2.o_ready); end
    endtask

    task automatic test_reset_midstream();
        req_t r;
        r = rand_req();
        drive6(r, 1'b1, 1'b0);
        tick();
        checks++; if (we6 !== 1'b1) begin errors++; $display("FAIL midrst_pre got=%0b exp=1", we6); end
        rst = 1'b1;
        tick();
        checks++; if (we6 !== 1'b0 || addr6 !== 6'd0 || data6 !== 32'd0 || count6 !== 7'd0) begin errors++; $display("FAIL midrst_outputs got=%0b/%0h/%08h/%0d exp=0/0/0/0", we6, addr6, data6, count6); end
        checks++; if (bus6.o_ready !== 1'b1 || done6 !== 1'b0 || full6 !== 1'b0) begin errors++; $display("FAIL midrst_status got=%0b/%0b/%0b exp=1/0/0", bus6.o_ready, done6, full6); end
        rst = 1'b0;
        drive6(r, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        restart6 = 1'b0;
        restart2 = 1'b0;
        rst = 1'b1;
        test_reset();
        test_fixed_vectors();
        test_back_to_back();
        test_random_streams();
        test_full();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
